// File: rtl/h_gate_sched.sv
`default_nettype none
// ============================================================================
// Module   : h_gate_sched
// Purpose  : Issues the read/write-back address pairs of one Hadamard pass
//            over a 2^NQ-entry amplitude RAM, one pair per cycle.
// Revision : 1.0  initial release
// ============================================================================
module h_gate_sched #(
    parameter int NQ     = 3,
    parameter int TW     = 3,
    parameter int RD_LAT = 1,
    parameter int HG_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] target,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [NQ-1:0] rd_addr_a,
    output logic [NQ-1:0] rd_addr_b,
    output logic          wr_en,
    output logic [NQ-1:0] wr_addr_a,
    output logic [NQ-1:0] wr_addr_b
);

    localparam int               c_depth  = RD_LAT + HG_LAT;
    localparam int               c_kw     = (NQ > 1) ? NQ - 1 : 1;
    localparam logic [c_kw-1:0]  c_k_last = c_kw'((1 << (NQ - 1)) - 1);
    localparam logic [TW:0]      c_nq     = (TW + 1)'(NQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [NQ-1:0] a;
        logic [NQ-1:0] b;
    } slot_t;

    state_t          r_state;
    logic [TW-1:0]   r_t;
    logic [c_kw-1:0] r_k;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_rd_en;
    logic [NQ-1:0]   r_rd_addr_a;
    logic [NQ-1:0]   r_rd_addr_b;
    slot_t           r_pipe [c_depth];

    logic [c_kw-1:0] w_k_next;
    logic [NQ-1:0]   w_next_a;
    logic [NQ-1:0]   w_next_bit;
    logic [NQ-1:0]   w_first_a;
    logic [NQ-1:0]   w_first_bit;
    logic            w_inflight;
    logic            w_last_wr;
    logic            w_target_ok;

    // Insert a zero at bit position t of pair index k to form the alpha address.
    function automatic logic [NQ-1:0] pair_addr(input logic [c_kw-1:0] k,
                                                input logic [TW-1:0]   t);
        logic [NQ-1:0] k_ext;
        logic [NQ-1:0] lo;
        k_ext = NQ'(k);
        lo    = (NQ'(1) << t) - NQ'(1);
        return ((k_ext & ~lo) << 1) | (k_ext & lo);
    endfunction

    assign w_k_next    = r_k + 1'b1;
    assign w_next_a    = pair_addr(w_k_next, r_t);
    assign w_next_bit  = NQ'(1) << r_t;
    assign w_first_a   = pair_addr('0, target);
    assign w_first_bit = NQ'(1) << target;
    assign w_target_ok = ({1'b0, target} < c_nq);

    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < c_depth - 1; i++) begin
            if (r_pipe[i].valid) begin
                w_inflight = 1'b1;
            end
        end
    end

    // The tap holds the final pair only when nothing is queued behind it.
    assign w_last_wr = r_pipe[c_depth-1].valid && !w_inflight && !r_rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_k         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_pipe[0] <= {r_rd_en, r_rd_addr_a, r_rd_addr_b};
            for (int i = 1; i < c_depth; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_target_ok) begin
                            r_t         <= target;
                            r_k         <= '0;
                            r_rd_en     <= 1'b1;
                            r_rd_addr_a <= w_first_a;
                            r_rd_addr_b <= w_first_a | w_first_bit;
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_k == c_k_last) begin
                        r_rd_en     <= 1'b0;
                        r_rd_addr_a <= '0;
                        r_rd_addr_b <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_k         <= w_k_next;
                        r_rd_addr_a <= w_next_a;
                        r_rd_addr_b <= w_next_a | w_next_bit;
                    end
                end
                S_DRAIN: begin
                    if (w_last_wr) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign wr_en     = r_pipe[c_depth-1].valid;
    assign wr_addr_a = r_pipe[c_depth-1].a;
    assign wr_addr_b = r_pipe[c_depth-1].b;

endmodule
`default_nettype wire

// File: tb/tb_h_gate_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_h_gate_sched
// Purpose  : Randomized self-checking bench for h_gate_sched against a
//            pass-timeline reference model with a RAM + h_gate datapath.
// Revision : 1.0  initial release
// ============================================================================
module tb_h_gate_sched;

    localparam int NQ     = 3;
    localparam int TW     = 3;
    localparam int RD_LAT = 1;
    localparam int HG_LAT = 2;
    localparam int P      = 1 << (NQ - 1);
    localparam int D      = RD_LAT + HG_LAT;
    localparam int N      = 1 << NQ;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          start  = 1'b0;
    logic [TW-1:0] target = '0;
    logic          busy, done, err, rd_en, wr_en;
    logic [NQ-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

    always #5 clk = ~clk;

    h_gate_sched #(.NQ(NQ), .TW(TW), .RD_LAT(RD_LAT), .HG_LAT(HG_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .target    (target),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a pass is an accept cycle plus its fixed timeline.
    bit pass_act = 0;
    int pass_s   = 0;
    int pass_t   = 0;
    bit err_pend = 0;
    int cyc      = 0;

    int ram    [N];
    int shadow [N];
    int na_q [$];
    int nb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pair_a(input int t, input int j);
        int n = 0;
        for (int i = 0; i < N; i++) begin
            if (((i >> t) & 1) == 0) begin
                if (n == j) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int hsum(input int a, input int b);
        return ((a + b) * 181) >>> 8;
    endfunction

    function automatic int hdif(input int a, input int b);
        return ((a - b) * 181) >>> 8;
    endfunction

    task automatic apply_shadow(input int t);
        int a, b;
        for (int i = 0; i < N; i++) begin
            if (((i >> t) & 1) == 0) begin
                a = shadow[i];
                b = shadow[i | (1 << t)];
                shadow[i]            = hsum(a, b);
                shadow[i | (1 << t)] = hdif(a, b);
            end
        end
    endtask

    task automatic step(input logic s, input logic [TW-1:0] tg);
        int r;
        bit act_rd, act_wr, exp_done, exp_busy, idle;
        @(negedge clk);
        r        = cyc - pass_s;
        act_rd   = pass_act && r >= 1 && r <= P;
        act_wr   = pass_act && r >= D + 1 && r <= D + P;
        exp_done = pass_act && r == P + D + 1;
        exp_busy = pass_act && r >= 1 && r <= P + D;
        chk("rd_en", rd_en, act_rd);
        chk("wr_en", wr_en, act_wr);
        chk("busy",  busy,  exp_busy);
        chk("done",  done,  exp_done);
        chk("err",   err,   err_pend);
        if (act_rd) begin
            chk("rd_addr_a", rd_addr_a, pair_a(pass_t, r - 1));
            chk("rd_addr_b", rd_addr_b, pair_a(pass_t, r - 1) | (1 << pass_t));
        end
        if (act_wr) begin
            chk("wr_addr_a", wr_addr_a, pair_a(pass_t, r - 1 - D));
            chk("wr_addr_b", wr_addr_b, pair_a(pass_t, r - 1 - D) | (1 << pass_t));
        end
        // RAM and h_gate as driven by the scheduler outputs
        if (wr_en === 1'b1 && na_q.size() > 0) begin
            ram[wr_addr_a] = na_q.pop_front();
            ram[wr_addr_b] = nb_q.pop_front();
        end
        if (rd_en === 1'b1) begin
            na_q.push_back(hsum(ram[rd_addr_a], ram[rd_addr_b]));
            nb_q.push_back(hdif(ram[rd_addr_a], ram[rd_addr_b]));
        end
        if (exp_done) apply_shadow(pass_t);
        idle = !pass_act || r >= P + D + 1;
        if (idle) pass_act = 0;
        err_pend = 0;
        if (idle && s) begin
            if (int'(tg) < NQ) begin
                pass_act = 1;
                pass_s   = cyc;
                pass_t   = int'(tg);
            end else begin
                err_pend = 1;
            end
        end
        start  = s;
        target = tg;
        cyc++;
    endtask

    task automatic idle_run(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_done"},  done,  0);
        chk({tag, "_err"},   err,   0);
        chk({tag, "_addr"},  {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}, 0);
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pass_act = 0;
        err_pend = 0;
        na_q.delete();
        nb_q.delete();
    endtask

    task automatic ram_compare(input string tag);
        for (int i = 0; i < N; i++) begin
            chk(tag, ram[i], shadow[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ram[i]    = int'($urandom_range(0, 200)) - 100;
            shadow[i] = ram[i];
        end
        #1;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_run(2);

        // target 0, then target NQ-1 (edge bit positions)
        step(1'b1, 3'd0);
        idle_run(12);
        step(1'b1, 3'd2);
        idle_run(12);
        ram_compare("ram_t1t2");

        // |000> with amp0=16, target 1
        for (int i = 0; i < N; i++) begin
            ram[i]    = 0;
            shadow[i] = 0;
        end
        ram[0]    = 16;
        shadow[0] = 16;
        step(1'b1, 3'd1);
        idle_run(12);
        chk("t3_amp0", ram[0], 11);
        chk("t3_amp2", ram[2], 11);
        chk("t3_amp1", ram[1], 0);
        chk("t3_amp3", ram[3], 0);
        ram_compare("ram_t3");

        // out-of-range target
        step(1'b1, 3'd3);
        idle_run(4);
        step(1'b1, 3'd7);
        idle_run(4);

        // reset in cycle 3 of a pass, then a clean pass
        step(1'b1, 3'd0);
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        mid_reset();
        idle_run(12);
        for (int i = 0; i < N; i++) shadow[i] = ram[i];
        step(1'b1, 3'd0);
        idle_run(12);

        // start held high: back-to-back passes
        repeat (40) step(1'b1, TW'($urandom_range(0, NQ - 1)));
        idle_run(12);

        // randomized starts and targets, including invalid ones
        repeat (400) step($urandom_range(0, 3) == 0, TW'($urandom_range(0, 7)));
        idle_run(12);
        ram_compare("ram_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
